// File: rtl/prog_loader.sv
// prog_loader: holds a program image and shifts it serially into a target over
// 1/2/4/8 MOSI lanes, then runs the target and measures run length in sclk periods.
`default_nettype none

module prog_loader #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int LANES    = 1,
  parameter int CLK_DIV  = 4,
  parameter int RST_SCLK = 4,
  parameter int TIMEOUT  = 1024,
  parameter int ADDR_W   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              img_we,
  input  logic [ADDR_W-1:0] img_waddr,
  input  logic [DATA_W-1:0] img_wdata,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [31:0]       run_cycles,
  output logic              sclk_out,
  output logic              rst_n_out,
  output logic [LANES-1:0]  mosi_out,
  output logic [1:0]        mode_out,
  input  logic              done_in
);

  localparam int BEATS  = DATA_W / LANES;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int RCNT_W = (RST_SCLK > 1) ? $clog2(RST_SCLK) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_TRST = 3'd1,
    S_LOAD = 3'd2,
    S_RUN  = 3'd3,
    S_FIN  = 3'd4
  } state_t;

  state_t state, next_state;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DIV_W-1:0]  div_cnt;
  logic [RCNT_W-1:0] rst_cnt;
  logic [BEAT_W-1:0] beat;
  logic [ADDR_W:0]   word_idx;
  logic [ADDR_W:0]   len_q;
  logic [DATA_W-1:0] shreg;
  logic              done_meta, done_sync;

  logic              active, next_active, tick, sclk_rise, sclk_fall;
  logic              last_beat, words_done, hit_timeout, wr_in_range;
  logic [ADDR_W:0]   next_idx, len_clamped;
  logic [DATA_W-1:0] first_word, next_word;

  assign active      = (state == S_TRST) || (state == S_LOAD) || (state == S_RUN);
  assign next_active = (next_state == S_TRST) || (next_state == S_LOAD) || (next_state == S_RUN);
  assign tick        = active && (div_cnt == DIV_W'(CLK_DIV - 1));
  assign sclk_rise   = tick && !sclk_out;
  assign sclk_fall   = tick && sclk_out;
  assign last_beat   = (beat == BEAT_W'(BEATS - 1));
  assign next_idx    = word_idx + 1'b1;
  assign words_done  = (next_idx == len_q);
  assign first_word  = mem[0];
  assign next_word   = mem[next_idx[ADDR_W-1:0]];
  assign hit_timeout = (run_cycles >= 32'(TIMEOUT));
  assign len_clamped = (len > DEPTH_L) ? DEPTH_L : len;

  // A power-of-two depth makes every address legal, so no compare is needed.
  generate
    if (DEPTH == (1 << ADDR_W)) begin : g_full_depth
      assign wr_in_range = 1'b1;
    end else begin : g_partial_depth
      assign wr_in_range = ({1'b0, img_waddr} < DEPTH_L);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (img_we && !busy && wr_in_range) mem[img_waddr] <= img_wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    busy       = (state != S_IDLE);
    done       = (state == S_FIN);
    mode_out   = 2'b00;
    case (state)
      S_IDLE: if (start) next_state = S_TRST;
      S_TRST: if (sclk_fall && rst_cnt == RCNT_W'(RST_SCLK - 1))
                next_state = (len_q != '0) ? S_LOAD : S_RUN;
      S_LOAD: begin
        mode_out = 2'b01;
        if (sclk_fall && last_beat && words_done) next_state = S_RUN;
      end
      S_RUN: begin
        mode_out = 2'b10;
        // done_in has priority over an expiring timeout
        if (done_sync)        next_state = S_FIN;
        else if (hit_timeout) next_state = S_FIN;
      end
      S_FIN:   next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt    <= '0;
      sclk_out   <= 1'b0;
      rst_n_out  <= 1'b0;
      mosi_out   <= '0;
      timeout    <= 1'b0;
      run_cycles <= '0;
      rst_cnt    <= '0;
      beat       <= '0;
      word_idx   <= '0;
      len_q      <= '0;
      shreg      <= '0;
      done_meta  <= 1'b0;
      done_sync  <= 1'b0;
    end else begin
      done_meta <= done_in;
      done_sync <= done_meta;

      // Divider restarts from zero on every entry into the clocked states.
      if (!active || !next_active) begin
        div_cnt  <= '0;
        sclk_out <= 1'b0;
      end else if (tick) begin
        div_cnt  <= '0;
        sclk_out <= ~sclk_out;
      end else begin
        div_cnt  <= div_cnt + 1'b1;
      end

      case (state)
        S_IDLE: if (start) begin
          timeout    <= 1'b0;
          run_cycles <= '0;
          len_q      <= len_clamped;
          rst_n_out  <= 1'b0;
          rst_cnt    <= '0;
        end
        S_TRST: if (sclk_fall) begin
          rst_cnt <= rst_cnt + 1'b1;
          if (next_state != S_TRST) begin
            rst_n_out <= 1'b1;
            word_idx  <= '0;
            beat      <= '0;
            if (next_state == S_LOAD) begin
              mosi_out <= first_word[DATA_W-1 -: LANES];
              shreg    <= first_word << LANES;
            end
          end
        end
        S_LOAD: if (sclk_fall) begin
          if (!last_beat) begin
            mosi_out <= shreg[DATA_W-1 -: LANES];
            shreg    <= shreg << LANES;
            beat     <= beat + 1'b1;
          end else if (!words_done) begin
            word_idx <= next_idx;
            beat     <= '0;
            mosi_out <= next_word[DATA_W-1 -: LANES];
            shreg    <= next_word << LANES;
          end else begin
            mosi_out <= '0;
          end
        end
        S_RUN: begin
          if (sclk_rise && next_state == S_RUN && run_cycles != 32'hFFFF_FFFF)
            run_cycles <= run_cycles + 1'b1;
          if (next_state == S_FIN && !done_sync) timeout <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: serial load (1 and 4 lanes), run/done, timeout,
// ignored start/write while busy, zero-length load and mid-load reset.
`default_nettype none

module tb_prog_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       img_we;
  logic [3:0] img_waddr;
  logic [7:0] img_wdata;
  logic [4:0] len;
  logic       start_a, start_b, done_in_a, done_in_b;

  logic        busy_a, done_a, timeout_a, sclk_a, rstn_out_a;
  logic [31:0] run_a;
  logic [0:0]  mosi_a;
  logic [1:0]  mode_a;
  logic        busy_b, done_b, timeout_b, sclk_b, rstn_out_b;
  logic [31:0] run_b;
  logic [3:0]  mosi_b;
  logic [1:0]  mode_b;

  int n_checks = 0;
  int n_fail   = 0;

  int         load_edges_a = 0;
  int         run_edges_a  = 0;
  int         trst_clks_a  = 0;
  logic [7:0] cap_a[$];
  logic [3:0] cap_b[$];

  always #5 clk = ~clk;

  prog_loader #(.TIMEOUT(50)) dut_a (
    .clk(clk), .rst_n(rst_n), .img_we(img_we), .img_waddr(img_waddr),
    .img_wdata(img_wdata), .start(start_a), .len(len), .busy(busy_a),
    .done(done_a), .timeout(timeout_a), .run_cycles(run_a), .sclk_out(sclk_a),
    .rst_n_out(rstn_out_a), .mosi_out(mosi_a), .mode_out(mode_a), .done_in(done_in_a)
  );

  prog_loader #(.LANES(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .img_we(img_we), .img_waddr(img_waddr),
    .img_wdata(img_wdata), .start(start_b), .len(len), .busy(busy_b),
    .done(done_b), .timeout(timeout_b), .run_cycles(run_b), .sclk_out(sclk_b),
    .rst_n_out(rstn_out_b), .mosi_out(mosi_b), .mode_out(mode_b), .done_in(done_in_b)
  );

  // Target-side model: samples MOSI on the sclk rising edge.
  always @(posedge sclk_a) begin
    if (mode_a == 2'b01) begin
      load_edges_a++;
      cap_a.push_back({7'd0, mosi_a});
    end else if (mode_a == 2'b10) begin
      run_edges_a++;
    end
  end

  always @(posedge sclk_b) if (mode_b == 2'b01) cap_b.push_back(mosi_b);

  always @(negedge clk) if (busy_a && !rstn_out_a) trst_clks_a++;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] byte_a(input int i);
    logic [7:0] b = 8'h00;
    for (int k = 0; k < 8; k++) b = {b[6:0], cap_a[8*i+k][0]};
    return b;
  endfunction

  task automatic clear_mon();
    load_edges_a = 0; run_edges_a = 0; trst_clks_a = 0;
    cap_a.delete(); cap_b.delete();
  endtask

  task automatic pulse_start_a();
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
  endtask

  task automatic wait_mode_a(input logic [1:0] m, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (mode_a == m) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_done_a(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_a) begin ok = 1'b1; break; end
    end
  endtask

  task automatic finish_a(output bit ok);
    done_in_a = 1'b1;
    wait_done_a(100, ok);
    done_in_a = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic write_word(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    img_we = 1'b1; img_waddr = a; img_wdata = d;
    @(negedge clk);
    img_we = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_a); end
    n_checks++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done_a); end
    n_checks++; if (timeout_a !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b want 0", timeout_a); end
    n_checks++; if (run_a !== 32'd0) begin n_fail++; $display("FAIL reset_run_cycles: got %0d want 0", run_a); end
    n_checks++; if ({sclk_a, rstn_out_a, mosi_a, mode_a} !== 5'b0) begin
      n_fail++; $display("FAIL reset_target_pins: got sclk=%b rstn=%b mosi=%b mode=%b want all 0",
                         sclk_a, rstn_out_a, mosi_a, mode_a);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_serial_load();
    bit ok;
    clear_mon();
    len = 5'd3;
    pulse_start_a();
    n_checks++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL load_busy: got %b want 1", busy_a); end
    wait_mode_a(2'b10, 2000, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL load_reach_run: got no RUN want RUN within 2000 clk"); end
    n_checks++; if (trst_clks_a != 32) begin n_fail++; $display("FAIL load_trst_len: got %0d clk want 32", trst_clks_a); end
    n_checks++; if (load_edges_a != 24) begin n_fail++; $display("FAIL load_edges: got %0d want 24", load_edges_a); end
    if (cap_a.size() >= 24) begin
      n_checks++; if ({byte_a(0), byte_a(1), byte_a(2)} !== 24'hA53CFF) begin
        n_fail++; $display("FAIL load_bytes: got %h%h%h want a53cff", byte_a(0), byte_a(1), byte_a(2));
      end
    end
    n_checks++; if (mosi_a !== 1'b0) begin n_fail++; $display("FAIL run_mosi: got %b want 0", mosi_a); end
    n_checks++; if (rstn_out_a !== 1'b1) begin n_fail++; $display("FAIL run_rstn: got %b want 1", rstn_out_a); end
    finish_a(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL load_finish: got no done want done pulse"); end
    n_checks++; if (rstn_out_a !== 1'b1) begin n_fail++; $display("FAIL idle_rstn_held: got %b want 1", rstn_out_a); end
  endtask

  task automatic test_lanes4();
    bit ok = 1'b0;
    clear_mon();
    len = 5'd3;
    @(negedge clk); start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (mode_b == 2'b10) begin ok = 1'b1; break; end
    end
    n_checks++; if (!ok) begin n_fail++; $display("FAIL lanes4_reach_run: got no RUN want RUN"); end
    n_checks++; if (cap_b.size() != 6) begin n_fail++; $display("FAIL lanes4_edges: got %0d want 6", cap_b.size()); end
    if (cap_b.size() == 6) begin
      n_checks++; if ({cap_b[0], cap_b[1], cap_b[2], cap_b[3], cap_b[4], cap_b[5]} !== 24'hA53CFF) begin
        n_fail++; $display("FAIL lanes4_nibbles: got %h%h%h%h%h%h want a53cff",
                           cap_b[0], cap_b[1], cap_b[2], cap_b[3], cap_b[4], cap_b[5]);
      end
    end
    done_in_b = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done_b) begin ok = 1'b1; break; end
    end
    n_checks++; if (!ok) begin n_fail++; $display("FAIL lanes4_done: got no done want done pulse"); end
    done_in_b = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_done_run();
    bit ok;
    clear_mon();
    len = 5'd3;
    pulse_start_a();
    wait_mode_a(2'b10, 2000, ok);
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (run_edges_a == 10) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    n_checks++; if (!ok) begin n_fail++; $display("FAIL done_run_edges: got %0d want 10", run_edges_a); end
    done_in_a = 1'b1;
    wait_done_a(50, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL done_pulse: got no done want done pulse"); end
    n_checks++; if (run_a !== 32'd10) begin n_fail++; $display("FAIL done_run_cycles: got %0d want 10", run_a); end
    n_checks++; if (timeout_a !== 1'b0) begin n_fail++; $display("FAIL done_timeout: got %b want 0", timeout_a); end
    n_checks++; if ({mode_a, sclk_a, rstn_out_a} !== 4'b0001) begin
      n_fail++; $display("FAIL fin_pins: got mode=%b sclk=%b rstn=%b want 00 0 1", mode_a, sclk_a, rstn_out_a);
    end
    @(negedge clk);
    done_in_a = 1'b0;
    n_checks++; if ({done_a, busy_a} !== 2'b00) begin
      n_fail++; $display("FAIL after_fin: got done=%b busy=%b want 0 0", done_a, busy_a);
    end
    repeat (20) @(negedge clk);
    n_checks++; if (run_a !== 32'd10) begin n_fail++; $display("FAIL run_cycles_frozen: got %0d want 10", run_a); end
  endtask

  task automatic test_timeout();
    bit ok;
    len = 5'd3;
    pulse_start_a();
    wait_done_a(2000, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL timeout_done: got no done want done pulse"); end
    n_checks++; if (run_a !== 32'd50) begin n_fail++; $display("FAIL timeout_run_cycles: got %0d want 50", run_a); end
    n_checks++; if (timeout_a !== 1'b1) begin n_fail++; $display("FAIL timeout_flag: got %b want 1", timeout_a); end
    repeat (5) @(negedge clk);
    n_checks++; if (timeout_a !== 1'b1) begin n_fail++; $display("FAIL timeout_sticky: got %b want 1", timeout_a); end
    pulse_start_a();
    n_checks++; if ({timeout_a, busy_a} !== 2'b01 || run_a !== 32'd0) begin
      n_fail++; $display("FAIL restart_clear: got timeout=%b busy=%b run=%0d want 0 1 0", timeout_a, busy_a, run_a);
    end
    wait_done_a(2000, ok);
    n_checks++; if (!ok || timeout_a !== 1'b1) begin
      n_fail++; $display("FAIL timeout_again: got done=%b timeout=%b want 1 1", ok, timeout_a);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_ignored_while_busy();
    bit ok;
    clear_mon();
    len = 5'd3;
    pulse_start_a();
    wait_mode_a(2'b01, 2000, ok);
    repeat (20) @(negedge clk);
    start_a = 1'b1; img_we = 1'b1; img_waddr = 4'd0; img_wdata = 8'h00;
    @(negedge clk);
    start_a = 1'b0; img_we = 1'b0;
    n_checks++; if (mode_a !== 2'b01) begin n_fail++; $display("FAIL busy_start_mode: got %b want 01", mode_a); end
    wait_mode_a(2'b10, 2000, ok);
    n_checks++; if (load_edges_a != 24 || trst_clks_a != 32) begin
      n_fail++; $display("FAIL busy_start_ignored: got edges=%0d trst=%0d want 24 32", load_edges_a, trst_clks_a);
    end
    finish_a(ok);
    clear_mon();
    len = 5'd1;
    pulse_start_a();
    wait_mode_a(2'b10, 2000, ok);
    n_checks++; if (cap_a.size() != 8 || byte_a(0) !== 8'hA5) begin
      n_fail++; $display("FAIL busy_write_dropped: got n=%0d mem0=%h want 8 a5", cap_a.size(), byte_a(0));
    end
    finish_a(ok);
    clear_mon();
    len = 5'd0;
    pulse_start_a();
    wait_mode_a(2'b10, 2000, ok);
    n_checks++; if (!ok || load_edges_a != 0 || trst_clks_a != 32) begin
      n_fail++; $display("FAIL len0: got run=%b edges=%0d trst=%0d want 1 0 32", ok, load_edges_a, trst_clks_a);
    end
    finish_a(ok);
  endtask

  task automatic test_reset_midload();
    bit ok = 1'b0;
    clear_mon();
    len = 5'd3;
    pulse_start_a();
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (load_edges_a >= 10) begin ok = 1'b1; break; end
    end
    n_checks++; if (!ok || mode_a !== 2'b01) begin n_fail++; $display("FAIL midload_reach: got mode=%b want 01", mode_a); end
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++; if ({busy_a, done_a, timeout_a, sclk_a, rstn_out_a, mosi_a, mode_a} !== 8'b0 || run_a !== 32'd0) begin
      n_fail++; $display("FAIL midload_reset: got busy=%b done=%b to=%b sclk=%b rstn=%b mosi=%b mode=%b run=%0d want all 0",
                         busy_a, done_a, timeout_a, sclk_a, rstn_out_a, mosi_a, mode_a, run_a);
    end
    rst_n = 1'b1;
    clear_mon();
    pulse_start_a();
    wait_mode_a(2'b10, 2000, ok);
    n_checks++; if (load_edges_a != 24 || cap_a.size() != 24) begin
      n_fail++; $display("FAIL reload_edges: got %0d want 24", load_edges_a);
    end else begin
      n_checks++; if ({byte_a(0), byte_a(1), byte_a(2)} !== 24'hA53CFF) begin
        n_fail++; $display("FAIL reload_bytes: got %h%h%h want a53cff", byte_a(0), byte_a(1), byte_a(2));
      end
    end
    finish_a(ok);
  endtask

  initial begin
    rst_n = 1'b0; img_we = 1'b0; img_waddr = '0; img_wdata = '0; len = '0;
    start_a = 1'b0; start_b = 1'b0; done_in_a = 1'b0; done_in_b = 1'b0;
    test_reset();
    write_word(4'd0, 8'hA5);
    write_word(4'd1, 8'h3C);
    write_word(4'd2, 8'hFF);
    write_word(4'd3, 8'h5A);
    test_serial_load();
    test_lanes4();
    test_done_run();
    test_timeout();
    test_ignored_while_busy();
    test_reset_midload();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
